// File: rtl/voting_stream_plurality.sv
// Streaming plurality vote: per-candidate counters filled from a valid/ready vote
// stream, scanned once per batch to present winner, its count and a tie flag.
module voting_stream_plurality #(
    parameter int unsigned N = 1,
    parameter int unsigned M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vote_valid,
    output logic         vote_ready,
    input  logic [N-1:0] vote_data,
    input  logic         vote_last,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [N-1:0] winner,
    output logic [M:0]   winner_count,
    output logic         tie
);

    localparam int unsigned NumCand = 2 ** N;
    localparam int unsigned CntW    = M + 1;
    localparam int unsigned IdxW    = N;
    // Total just before the vote that fills the batch to 2**M.
    localparam logic [M:0]   LastTotal = CntW'((2 ** M) - 1);
    localparam logic [N-1:0] LastIdx   = IdxW'(NumCand - 1);

    typedef enum logic [1:0] {
        StAccum,
        StScan,
        StDone
    } state_e;

    state_e       state_q, state_d;
    logic [M:0]   cnt_q [NumCand];
    logic [M:0]   cnt_d [NumCand];
    logic [M:0]   total_q, total_d;
    logic [N-1:0] scan_idx_q, scan_idx_d;
    logic [N-1:0] best_idx_q, best_idx_d;
    logic [M:0]   best_cnt_q, best_cnt_d;
    logic         tie_q, tie_d;
    logic         vote_fire;
    logic         result_fire;

    assign vote_ready   = (state_q == StAccum);
    assign result_valid = (state_q == StDone);
    assign vote_fire    = vote_valid & vote_ready;
    assign result_fire  = result_valid & result_ready;
    assign winner       = best_idx_q;
    assign winner_count = best_cnt_q;
    assign tie          = tie_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        total_d    = total_q;
        scan_idx_d = scan_idx_q;
        best_idx_d = best_idx_q;
        best_cnt_d = best_cnt_q;
        tie_d      = tie_q;

        unique case (state_q)
            StAccum: begin
                if (vote_fire) begin
                    cnt_d[vote_data] = cnt_q[vote_data] + CntW'(1);
                    total_d          = total_q + CntW'(1);
                    if (vote_last || (total_q == LastTotal)) begin
                        state_d    = StScan;
                        scan_idx_d = '0;
                    end
                end
            end
            StScan: begin
                // Strict > keeps the lowest index on equal counts.
                if (scan_idx_q == '0) begin
                    best_idx_d = '0;
                    best_cnt_d = cnt_q[0];
                    tie_d      = 1'b0;
                end else if (cnt_q[scan_idx_q] > best_cnt_q) begin
                    best_idx_d = scan_idx_q;
                    best_cnt_d = cnt_q[scan_idx_q];
                    tie_d      = 1'b0;
                end else if (cnt_q[scan_idx_q] == best_cnt_q) begin
                    tie_d = 1'b1;
                end
                scan_idx_d = scan_idx_q + IdxW'(1);
                if (scan_idx_q == LastIdx) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (result_fire) begin
                    for (int unsigned i = 0; i < NumCand; i++) begin
                        cnt_d[i] = '0;
                    end
                    total_d = '0;
                    state_d = StAccum;
                end
            end
            default: begin
                state_d = StAccum;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAccum;
            for (int unsigned i = 0; i < NumCand; i++) begin
                cnt_q[i] <= '0;
            end
            total_q    <= '0;
            scan_idx_q <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
            tie_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            total_q    <= total_d;
            scan_idx_q <= scan_idx_d;
            best_idx_q <= best_idx_d;
            best_cnt_q <= best_cnt_d;
            tie_q      <= tie_d;
        end
    end

endmodule

// File: tb/tb_voting_stream_plurality.sv
// Bench for voting_stream_plurality: three configurations driven in turn, results
// predicted by a scoreboard when votes close a batch and checked at the handshake.
module tb_voting_stream_plurality;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] sel;
    logic       vote_valid;
    logic       vote_last;
    logic       result_ready;
    logic [2:0] vote_data;
    logic [2:0] vv;
    logic [2:0] vr;
    logic [2:0] rv;
    logic [2:0] tie_v;
    logic [0:0] w0;
    logic [1:0] w1;
    logic [2:0] w2;
    logic [4:0] c0;
    logic [4:0] c1;
    logic [5:0] c2;

    assign vv[0] = vote_valid && (sel == 2'd0);
    assign vv[1] = vote_valid && (sel == 2'd1);
    assign vv[2] = vote_valid && (sel == 2'd2);

    voting_stream_plurality #(.N(1), .M(4)) u_n1 (
        .clk(clk), .rst(rst), .vote_valid(vv[0]), .vote_ready(vr[0]),
        .vote_data(vote_data[0:0]), .vote_last(vote_last), .result_valid(rv[0]),
        .result_ready(result_ready), .winner(w0), .winner_count(c0), .tie(tie_v[0])
    );
    voting_stream_plurality #(.N(2), .M(4)) u_n2 (
        .clk(clk), .rst(rst), .vote_valid(vv[1]), .vote_ready(vr[1]),
        .vote_data(vote_data[1:0]), .vote_last(vote_last), .result_valid(rv[1]),
        .result_ready(result_ready), .winner(w1), .winner_count(c1), .tie(tie_v[1])
    );
    voting_stream_plurality #(.N(3), .M(5)) u_n3 (
        .clk(clk), .rst(rst), .vote_valid(vv[2]), .vote_ready(vr[2]),
        .vote_data(vote_data), .vote_last(vote_last), .result_valid(rv[2]),
        .result_ready(result_ready), .winner(w2), .winner_count(c2), .tie(tie_v[2])
    );

    int obs_vready, obs_valid, obs_winner, obs_count, obs_tie;
    always_comb begin
        obs_vready = 0;
        obs_valid  = 0;
        obs_winner = 0;
        obs_count  = 0;
        obs_tie    = 0;
        case (sel)
            2'd0: begin
                obs_vready = int'(vr[0]); obs_valid = int'(rv[0]);
                obs_winner = int'(w0); obs_count = int'(c0); obs_tie = int'(tie_v[0]);
            end
            2'd1: begin
                obs_vready = int'(vr[1]); obs_valid = int'(rv[1]);
                obs_winner = int'(w1); obs_count = int'(c1); obs_tie = int'(tie_v[1]);
            end
            default: begin
                obs_vready = int'(vr[2]); obs_valid = int'(rv[2]);
                obs_winner = int'(w2); obs_count = int'(c2); obs_tie = int'(tie_v[2]);
            end
        endcase
    end

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        int winner;
        int count;
        int tie;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   mcnt[8];
    int   mtotal;
    int   passed = 0;
    int   failed = 0;
    int   total_checks = 0;
    int   prev_valid = 0;

    function automatic int nsel();
        return (sel == 2'd0) ? 1 : (sel == 2'd1) ? 2 : 3;
    endfunction

    function automatic int msel();
        return (sel == 2'd2) ? 5 : 4;
    endfunction

    task automatic check(string tag, int obs, int expv);
        total_checks++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mcnt[i] = 0;
        mtotal = 0;
    endtask

    // Winner is the first index holding the maximum; tie if the maximum repeats.
    task automatic model_accept(int d, bit last);
        int   mx;
        int   nmax;
        int   w;
        exp_t e;
        mcnt[d]++;
        mtotal++;
        if (last || mtotal == (1 << msel())) begin
            mx   = 0;
            nmax = 0;
            w    = -1;
            for (int i = 0; i < (1 << nsel()); i++) if (mcnt[i] > mx) mx = mcnt[i];
            for (int i = 0; i < (1 << nsel()); i++) begin
                if (mcnt[i] == mx) begin
                    if (w < 0) w = i;
                    nmax++;
                end
            end
            e.winner = w;
            e.count  = mx;
            e.tie    = (nmax > 1) ? 1 : 0;
            e.due    = cycle + (1 << nsel()) + 1;
            exp_q.push_back(e);
            model_reset();
        end
    endtask

    // Checks outputs of the current cycle, then advances to just after the next edge.
    task automatic tick();
        exp_t e;
        if (obs_valid == 1 && prev_valid == 0) begin
            if (exp_q.size() == 0) check("spurious_result", obs_valid, 0);
            else check("latency", cycle, exp_q[0].due);
        end
        if (obs_valid == 1 && result_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("winner", obs_winner, e.winner);
            check("winner_count", obs_count, e.count);
            check("tie", obs_tie, e.tie);
        end
        prev_valid = obs_valid;
        @(posedge clk);
        #1;
    endtask

    task automatic pick_dut(logic [1:0] s);
        sel = s;
        #1;
    endtask

    task automatic send_vote(int d, bit last);
        int waited = 0;
        vote_valid = 1'b1;
        vote_data  = 3'(d);
        vote_last  = last;
        while (obs_vready != 1 && waited < 200) begin
            tick();
            waited++;
        end
        if (obs_vready == 1) begin
            model_accept(d, last);
            tick();
        end else begin
            check("vote_accept_timeout", waited, 0);
        end
        vote_valid = 1'b0;
        vote_data  = 'x;
        vote_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || obs_valid == 1) && n < 300) begin
            tick();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_vote_ready"}, obs_vready, 1);
        check({tag, "_result_valid"}, obs_valid, 0);
        check({tag, "_winner"}, obs_winner, 0);
        check({tag, "_count"}, obs_count, 0);
        check({tag, "_tie"}, obs_tie, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int len;
        sel          = 2'd0;
        rst          = 1'b1;
        vote_valid   = 1'b0;
        vote_data    = '0;
        vote_last    = 1'b0;
        result_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        for (int s = 0; s < 3; s++) begin
            pick_dut(2'(s));
            check_reset_outputs("reset");
        end

        // N=1: ten ones against six zeros, last on the 16th vote.
        pick_dut(2'd0);
        for (int i = 0; i < 16; i++) send_vote(((i % 8) < 5) ? 1 : 0, i == 15);
        drain();

        // N=1: even split resolves to candidate 0 with tie.
        for (int i = 0; i < 16; i++) send_vote(i % 2, i == 15);
        drain();

        // N=2: 17 votes with no last; batch closes itself after 16.
        pick_dut(2'd1);
        for (int i = 0; i < 16; i++) send_vote(i % 4, 1'b0);
        check("autoclose_vote_ready", obs_vready, 0);
        send_vote(3, 1'b0);
        send_vote(3, 1'b1);
        drain();

        // N=3: tie between 2 and 5, result held under backpressure.
        pick_dut(2'd2);
        result_ready = 1'b0;
        send_vote(5, 1'b0);
        send_vote(5, 1'b0);
        send_vote(2, 1'b0);
        send_vote(2, 1'b0);
        send_vote(7, 1'b1);
        for (int n = 0; n < 50 && obs_valid != 1; n++) tick();
        check("hold_valid_seen", obs_valid, 1);
        vote_valid = 1'b1;
        vote_data  = 3'd7;
        vote_last  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check("hold_valid", obs_valid, 1);
            check("hold_winner", obs_winner, 2);
            check("hold_count", obs_count, 2);
            check("hold_tie", obs_tie, 1);
            check("hold_vote_ready", obs_vready, 0);
            tick();
        end
        vote_valid   = 1'b0;
        vote_last    = 1'b0;
        result_ready = 1'b1;
        tick();
        check("post_handshake_valid", obs_valid, 0);
        check("post_handshake_vote_ready", obs_vready, 1);
        send_vote(1, 1'b1);
        drain();

        // N=2: reset in the middle of the scan discards the batch.
        pick_dut(2'd1);
        send_vote(1, 1'b0);
        send_vote(2, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("mid_scan_reset");
        void'(exp_q.pop_back());
        prev_valid = 0;
        send_vote(3, 1'b1);
        drain();

        // N=1: single-vote batch.
        pick_dut(2'd0);
        send_vote(0, 1'b1);
        drain();

        // N=2: back-to-back random batches with result_ready held high.
        pick_dut(2'd1);
        for (int b = 0; b < 6; b++) begin
            len = int'($urandom_range(1, 6));
            for (int j = 0; j < len; j++) send_vote(int'($urandom_range(0, 3)), j == len - 1);
        end
        drain();

        $display("%0d/%0d checks passed", passed, total_checks);
        $finish;
    end

endmodule
